// File: rtl/guess_judge_pkg.sv
// guess_judge_pkg: shared verdict codes and FSM state encoding for guess_judge.
// Contents: RES_NONE/RES_LOW/RES_HIGH/RES_MATCH result codes, state_t round states.
package guess_judge_pkg;
    localparam logic [1:0] RES_NONE  = 2'b00;
    localparam logic [1:0] RES_LOW   = 2'b01;
    localparam logic [1:0] RES_HIGH  = 2'b10;
    localparam logic [1:0] RES_MATCH = 2'b11;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_WIN  = 2'b10,
        ST_LOSE = 2'b11
    } state_t;
endpackage

// File: rtl/guess_cmp.sv
// guess_cmp: combinational unsigned compare of a guess against the secret.
// Ports: guess, secret (W-bit in) -> verdict (2-bit result code out).
// Macro GUESS_JUDGE_HINT_EN: when defined, misses report LOW/HIGH; otherwise
// every miss reports LOW and no magnitude comparator is built.
module guess_cmp
    import guess_judge_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] guess,
    input  logic [W-1:0] secret,
    output logic [1:0]   verdict
);
    always_comb begin
`ifdef GUESS_JUDGE_HINT_EN
        verdict = (guess == secret) ? RES_MATCH : (guess < secret) ? RES_LOW : RES_HIGH;
`else
        verdict = (guess == secret) ? RES_MATCH : RES_LOW;
`endif
    end
endmodule

// File: rtl/guess_judge.sv
// guess_judge: latches a secret on start, judges valid guesses with a registered
// verdict, counts attempts and ends the round in WIN or LOSE.
// Ports: clk, rst_n (async active-low), start, secret[W], guess_valid, guess[W]
//        -> result[2], result_valid, tries_left[CW], done, won.
// Macro GUESS_JUDGE_HINT_EN selects LOW/HIGH hints inside guess_cmp.
module guess_judge
    import guess_judge_pkg::*;
#(
    parameter  int W         = 4,
    parameter  int MAX_TRIES = 7,
    localparam int CW        = $clog2(MAX_TRIES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  secret,
    input  logic          guess_valid,
    input  logic [W-1:0]  guess,
    output logic [1:0]    result,
    output logic          result_valid,
    output logic [CW-1:0] tries_left,
    output logic          done,
    output logic          won
);
    state_t        state_q, state_d;
    logic [W-1:0]  secret_q, secret_d;
    logic [CW-1:0] tries_q, tries_d;
    logic [1:0]    result_q, result_d;
    logic          rv_q, rv_d;
    logic          done_q, done_d;
    logic          won_q, won_d;
    logic [1:0]    verdict;

    guess_cmp #(.W(W)) u_cmp (
        .guess   (guess),
        .secret  (secret_q),
        .verdict (verdict)
    );

    always_comb begin
        state_d  = state_q;
        secret_d = secret_q;
        tries_d  = tries_q;
        result_d = result_q;
        rv_d     = 1'b0;
        if (start) begin
            state_d  = ST_PLAY;
            secret_d = secret;
            tries_d  = CW'(MAX_TRIES);
            result_d = RES_NONE;
        end else if (guess_valid && state_q == ST_PLAY) begin
            result_d = verdict;
            rv_d     = 1'b1;
            tries_d  = (tries_q == '0) ? '0 : tries_q - CW'(1);
            // A match on the last attempt still wins; only a miss at one try left loses.
            state_d  = (verdict == RES_MATCH) ? ST_WIN : (tries_q <= CW'(1)) ? ST_LOSE : ST_PLAY;
        end
        done_d = (state_d == ST_WIN) || (state_d == ST_LOSE);
        won_d  = (state_d == ST_WIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            secret_q <= '0;
            tries_q  <= '0;
            result_q <= RES_NONE;
            rv_q     <= 1'b0;
            done_q   <= 1'b0;
            won_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            secret_q <= secret_d;
            tries_q  <= tries_d;
            result_q <= result_d;
            rv_q     <= rv_d;
            done_q   <= done_d;
            won_q    <= won_d;
        end
    end

    assign result       = result_q;
    assign result_valid = rv_q;
    assign tries_left   = tries_q;
    assign done         = done_q;
    assign won          = won_q;
endmodule

// File: tb/tb_guess_judge.sv
// tb_guess_judge: directed and random checks of guess_judge against a round-level model.
module tb_guess_judge;
    localparam int W  = 4;
    localparam int MT = 3;
    localparam int CW = 2;
`ifdef GUESS_JUDGE_HINT_EN
    localparam bit hint_en = 1'b1;
`else
    localparam bit hint_en = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  secret = '0;
    logic          guess_valid = 1'b0;
    logic [W-1:0]  guess = '0;
    logic [1:0]    result;
    logic          result_valid;
    logic [CW-1:0] tries_left;
    logic          done;
    logic          won;

    int n_assert = 0;
    int n_fail = 0;

    // Round-level model: is a round open, how many tries remain, last verdict.
    int m_sec, m_tries, m_res;
    bit m_rv, m_open, m_done, m_won;

    always #5 clk = ~clk;

    guess_judge #(.W(W), .MAX_TRIES(MT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .secret       (secret),
        .guess_valid  (guess_valid),
        .guess        (guess),
        .result       (result),
        .result_valid (result_valid),
        .tries_left   (tries_left),
        .done         (done),
        .won          (won)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, " result"}, 32'(result), m_res);
        chk({ctx, " result_valid"}, 32'(result_valid), 32'(m_rv));
        chk({ctx, " tries_left"}, 32'(tries_left), m_tries);
        chk({ctx, " done"}, 32'(done), 32'(m_done));
        chk({ctx, " won"}, 32'(won), 32'(m_won));
    endtask

    task automatic model_reset();
        m_sec = 0; m_tries = 0; m_res = 0;
        m_rv = 0; m_open = 0; m_done = 0; m_won = 0;
    endtask

    task automatic model_step(input bit st, input int sec, input bit gv, input int g);
        m_rv = 0;
        if (st) begin
            m_sec = sec; m_tries = MT; m_res = 0;
            m_open = 1; m_done = 0; m_won = 0;
        end else if (gv && m_open) begin
            m_rv = 1;
            m_tries = m_tries - 1;
            if (g == m_sec) begin
                m_res = 3; m_open = 0; m_done = 1; m_won = 1;
            end else begin
                m_res = (hint_en && g > m_sec) ? 2 : 1;
                if (m_tries == 0) begin
                    m_open = 0; m_done = 1;
                end
            end
        end
    endtask

    task automatic step(input string ctx, input bit st, input int sec, input bit gv, input int g);
        @(negedge clk);
        start = st; secret = W'(sec); guess_valid = gv; guess = W'(g);
        @(posedge clk);
        model_step(st, sec, gv, g);
        #1;
        check_all(ctx);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step("idle_guess", 0, 0, 1, 3);
        step("start9", 1, 9, 0, 0);
        step("g3", 0, 0, 1, 3);
        step("g12", 0, 0, 1, 12);
        step("g9_win", 0, 0, 1, 9);
        step("win_hold", 0, 0, 0, 0);
        step("start5", 1, 5, 0, 0);
        step("g0", 0, 0, 1, 0);
        step("g1", 0, 0, 1, 1);
        step("g2_lose", 0, 0, 1, 2);
        step("lose_g5", 0, 0, 1, 5);
        step("start_and_guess", 1, 7, 1, 7);
        step("g7_next", 0, 0, 1, 7);
        step("start4", 1, 4, 0, 0);
        step("g0b", 0, 0, 1, 0);
        step("g1b", 0, 0, 1, 1);
        step("restart2", 1, 2, 0, 0);
        step("g2_win", 0, 0, 1, 2);
        step("start6", 1, 6, 0, 0);
        step("g1c", 0, 0, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_g6", 0, 0, 1, 6);
        step("post_rst_g6b", 0, 0, 1, 6);
        step("nohint_start9", 1, 9, 0, 0);
        step("nohint_g12", 0, 0, 1, 12);
        step("nohint_g9", 0, 0, 1, 9);
        for (int i = 0; i < 400; i++) begin
            bit st, gv;
            int sec, g;
            st = ($urandom_range(0, 9) == 0);
            gv = ($urandom_range(0, 3) != 0);
            sec = int'($urandom_range(0, 15));
            g = ($urandom_range(0, 3) == 0) ? m_sec : int'($urandom_range(0, 15));
            step("rand", st, sec, gv, g);
        end
        @(negedge clk);
        start = 1'b0; guess_valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
